bp_resolver: RTL and testbench
==============================

Name: bp_resolver

Overview:
- Write-side companion to the branch predictor cache `bpcache`.
- Records each fetch-time prediction (address and predicted direction) in an in-order queue.
- Pairs each prediction with its execute-stage outcome, in order.
- Drives the predictor's training port (`we`, `w_addr`, `did_branch`) and reports mispredicts to the pipeline.

Parameters:
- `ADDR_W`, 8: predictor index width. Must match `bpcache` `addr`/`w_addr`.
- `DEPTH`, 4: maximum number of unresolved predictions in flight. Must be a power of two, at least 2.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `pred_valid`  in  1  fetch issues a prediction this cycle
- `pred_addr`  in  `ADDR_W`  predictor index used at fetch
- `pred_taken`  in  1  direction the predictor returned
- `pred_ready`  out  1  queue can accept a prediction, equal to !full (combinational)
- `res_valid`  in  1  execute resolves the oldest branch this cycle
- `res_taken`  in  1  actual branch outcome
- `flush`  in  1  pipeline flush; discards all queued predictions
- `we`  out  1  training write strobe to `bpcache`
- `w_addr`  out  `ADDR_W`  training index to `bpcache`
- `did_branch`  out  1  training outcome to `bpcache`
- `mispredict`  out  1  one-cycle pulse: resolved outcome differs from the prediction
- `res_orphan`  out  1  one-cycle pulse: resolution arrived with the queue empty
- `count`  out  `$clog2(DEPTH+1)`  current occupancy

Behaviour:
- Reset (async assert, sync release by `clk`):
  - Queue empty, `count` = 0, `pred_ready` = 1.
  - `we`, `w_addr`, `did_branch`, `mispredict`, `res_orphan` all 0.
  - Reset mid-operation discards all entries and any pending output pulse immediately.
- Storage: circular buffer with head/tail pointers and a separate occupancy count, so full and empty are unambiguous. Pointers wrap modulo `DEPTH`.
- Push:
  - Occurs on a rising edge when `pred_valid` && `pred_ready`, and no flush or mispredict-clear happens that edge.
  - `pred_valid` while full is dropped silently; the queue is unchanged.
- Resolve (at the edge ending cycle N, with `res_valid` = 1 and the queue non-empty):
  - Pop the head entry.
  - In cycle N+1: `we` = 1, `w_addr` = head.addr, `did_branch` = `res_taken`, `mispredict` = (head.taken != `res_taken`).
  - All outputs are registered and last exactly one cycle; otherwise they return to 0. `w_addr` holds its last value.
  - Latency from `res_valid` to `we` is 1 cycle. With `bpcache`'s 1-cycle write, the trained value is readable by cycle N+3.
- Mispredict clear:
  - On the same edge as a mispredicting resolve, all remaining (younger, wrong-path) entries are discarded. `count` becomes 0.
  - A push on that edge is dropped.
- Resolve on empty: no pop and `we` stays 0. `res_orphan` = 1 in cycle N+1.
- Push and resolve on the same edge, no mispredict:
  - Both take effect and `count` is unchanged.
  - When the queue is full, `pred_ready` = 0, so no push occurs. There is no same-cycle bypass.
- `flush`:
  - If `res_valid` is also asserted, the resolve is processed first and the training write is still issued.
  - Then the queue is emptied and any same-edge push is dropped.
  - `flush` itself never generates `mispredict`.
- Training order: one update per resolved branch, in program order. Back-to-back resolves produce back-to-back `we` pulses.
- Arithmetic:
  - `count` increments or decrements by at most 1 per edge, except on a clear, which sets it to 0.
  - `count` never exceeds `DEPTH`.

Decomposition:
- Package `bp_pkg`:
  - `BP_ADDR_W` default constant.
  - `bp_entry_t` packed struct {addr[`ADDR_W`-1:0], taken}.
  - Shared with `bpcache` and the fetch stage.
- Sub-module `bp_fifo`: parameterised circular buffer with push, pop, clear, full, empty, count and head-data outputs.
- `bp_resolver` contains `bp_fifo` plus the registered training and pulse outputs.

Test Plan:
- Reset check:
  - Stimulus: hold `rst` = 1 for 3 cycles and drive random inputs.
  - Required: all outputs 0, `pred_ready` = 1. After release, `count` = 0.
- Fill and overflow:
  - Stimulus: push addrs 0x10..0x14 with taken = 1 on consecutive cycles.
  - Required: `count` = 4 and `pred_ready` = 0 after the fourth push; the fifth (0x14) is dropped.
  - Then resolve 4 times with taken = 1. Required: `we` pulses with `w_addr` 0x10..0x13 in order, `did_branch` = 1, `mispredict` = 0.
- Mispredict clear:
  - Stimulus: push 0x20/T, 0x21/N, 0x22/T, then resolve with `res_taken` = 0.
  - Required next cycle: `we` = 1, `w_addr` = 0x20, `did_branch` = 0, `mispredict` = 1, `count` = 0. A push on that edge is dropped.
- Orphan resolve:
  - Stimulus: empty queue, `res_valid` = 1.
  - Required: `res_orphan` = 1 for one cycle, `we` = 0, `count` = 0.
- Flush with simultaneous resolve and push:
  - Stimulus: queue holds 0x30/N, 0x31/N; on one edge assert `flush`, `res_valid` with taken = 0, and `pred_valid` (0x32).
  - Required: `we` = 1, `w_addr` = 0x30, `mispredict` = 0, `count` = 0.
- Reset mid-operation and integration with `bpcache`:
  - Stimulus: with 3 entries queued, assert `rst` asynchronously between edges.
  - Required: outputs and `count` go to 0 immediately.
  - Then connect to `bpcache`, push 0x05/N, and resolve taken twice.
  - Required: `bpcache` `branch` reads 1 at 0x05.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: default index width and the queued
// prediction record used by the fetch stage, bp_resolver and bpcache.
package bp_pkg;

  localparam int BP_ADDR_W = 8;

  typedef struct packed {
    logic [BP_ADDR_W-1:0] addr;
    logic                 taken;
  } bp_entry_t;

endpackage

// File: rtl/bp_fifo.sv
// Circular buffer with head/tail pointers and an explicit occupancy count,
// so full and empty never alias. Clear has priority over push and pop.
module bp_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[head_ptr];
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty;

  // NOTE: storage is not reset; entries are only ever read below count, so
  // resetting the pointers and count is enough and keeps the array as plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= din;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (do_pop)  head_ptr <= head_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/bp_resolver.sv
// Pairs in-order fetch predictions with execute outcomes, drives the bpcache
// training port and flags mispredicts / orphan resolutions.
module bp_resolver
  import bp_pkg::*;
#(
  parameter int ADDR_W = BP_ADDR_W,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  input  logic [ADDR_W-1:0] pred_addr,
  input  logic              pred_taken,
  output logic              pred_ready,
  input  logic              res_valid,
  input  logic              res_taken,
  input  logic              flush,
  output logic              we,
  output logic [ADDR_W-1:0] w_addr,
  output logic              did_branch,
  output logic              mispredict,
  output logic              res_orphan,
  output logic [CNT_W-1:0]  count
);

  // Same layout as bp_entry_t, but sized by this instance's ADDR_W.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              taken;
  } entry_t;

  entry_t head;
  entry_t din;
  logic   full;
  logic   empty;
  logic   resolve;
  logic   wrong;
  logic   clear;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave a value held and infer a latch.
    din     = '0;
    resolve = 1'b0;
    wrong   = 1'b0;
    din.addr  = pred_addr;
    din.taken = pred_taken;
    resolve   = res_valid && !empty;
    wrong     = resolve && (head.taken != res_taken);
  end

  // A mispredict squashes every younger wrong-path entry and the same-edge push.
  assign clear      = flush || wrong;
  assign pred_ready = !full;

  bp_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pred_valid && pred_ready),
    .pop   (resolve),
    .clear (clear),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we         <= 1'b0;
      w_addr     <= '0;
      did_branch <= 1'b0;
      mispredict <= 1'b0;
      res_orphan <= 1'b0;
    end else begin
      we         <= resolve;
      did_branch <= resolve && res_taken;
      mispredict <= wrong;
      res_orphan <= res_valid && empty;
      if (resolve) w_addr <= head.addr;
    end
  end

endmodule

// File: tb/tb_bp_resolver.sv
// Directed bench for bp_resolver with a tiny behavioural bpcache write model.
module tb_bp_resolver;

  logic       clk = 1'b0;
  logic       rst;
  logic       pred_valid;
  logic [7:0] pred_addr;
  logic       pred_taken;
  logic       pred_ready;
  logic       res_valid;
  logic       res_taken;
  logic       flush;
  logic       we;
  logic [7:0] w_addr;
  logic       did_branch;
  logic       mispredict;
  logic       res_orphan;
  logic [2:0] count;

  logic       cache [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bp_resolver #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pred_valid (pred_valid),
    .pred_addr  (pred_addr),
    .pred_taken (pred_taken),
    .pred_ready (pred_ready),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .flush      (flush),
    .we         (we),
    .w_addr     (w_addr),
    .did_branch (did_branch),
    .mispredict (mispredict),
    .res_orphan (res_orphan),
    .count      (count)
  );

  // Behavioural stand-in for bpcache's 1-cycle training write.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) cache[i] <= 1'b0;
    end else if (we) begin
      cache[w_addr] <= did_branch;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid = 1'b0;
    pred_addr  = '0;
    pred_taken = 1'b0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic push(input logic [7:0] a, input logic t);
    pred_valid = 1'b1;
    pred_addr  = a;
    pred_taken = t;
  endtask

  task automatic check_out(input string tag, input logic w, input logic [7:0] wa,
                           input logic db, input logic mp, input logic [2:0] cnt);
    check({tag, ".we"}, 32'(we), 32'(w));
    check({tag, ".w_addr"}, 32'(w_addr), 32'(wa));
    check({tag, ".did_branch"}, 32'(did_branch), 32'(db));
    check({tag, ".mispredict"}, 32'(mispredict), 32'(mp));
    check({tag, ".count"}, 32'(count), 32'(cnt));
  endtask

  initial begin
    // Reset held for 3 cycles with random inputs.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pred_valid = 1'($urandom);
      pred_addr  = 8'($urandom);
      pred_taken = 1'($urandom);
      res_valid  = 1'($urandom);
      res_taken  = 1'($urandom);
      flush      = 1'($urandom);
      step();
      check_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
      check("reset.res_orphan", 32'(res_orphan), 32'd0);
      check("reset.pred_ready", 32'(pred_ready), 32'd1);
    end
    idle();
    rst = 1'b0;
    step();
    check("post_reset.count", 32'(count), 32'd0);

    // Fill to DEPTH; the fifth push must be dropped.
    for (int i = 0; i < 5; i++) begin
      push(8'h10 + 8'(i), 1'b1);
      step();
      check("fill.count", 32'(count), (i < 4) ? 32'(i + 1) : 32'd4);
      check("fill.pred_ready", 32'(pred_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    idle();
    res_valid = 1'b1;
    res_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("drain", 1'b1, 8'h10 + 8'(i), 1'b1, 1'b0, 3'(3 - i));
    end
    idle();
    step();
    check_out("drain_idle", 1'b0, 8'h13, 1'b0, 1'b0, 3'd0);

    // Mispredict clears younger entries and drops the same-edge push.
    push(8'h20, 1'b1); step();
    push(8'h21, 1'b0); step();
    push(8'h22, 1'b1); step();
    check("mp_fill.count", 32'(count), 32'd3);
    push(8'h23, 1'b1);
    res_valid = 1'b1;
    res_taken = 1'b0;
    step();
    check_out("mispredict", 1'b1, 8'h20, 1'b0, 1'b1, 3'd0);
    idle();
    step();
    check_out("mp_after", 1'b0, 8'h20, 1'b0, 1'b0, 3'd0);

    // Orphan resolve on an empty queue.
    res_valid = 1'b1;
    res_taken = 1'b1;
    step();
    check("orphan.res_orphan", 32'(res_orphan), 32'd1);
    check_out("orphan", 1'b0, 8'h20, 1'b0, 1'b0, 3'd0);
    idle();
    step();
    check("orphan_after.res_orphan", 32'(res_orphan), 32'd0);

    // Flush together with a resolve and a push.
    push(8'h30, 1'b0); step();
    push(8'h31, 1'b0); step();
    check("flush_fill.count", 32'(count), 32'd2);
    push(8'h32, 1'b1);
    res_valid = 1'b1;
    res_taken = 1'b0;
    flush     = 1'b1;
    step();
    check_out("flush", 1'b1, 8'h30, 1'b0, 1'b0, 3'd0);
    idle();
    step();
    check("flush_after.count", 32'(count), 32'd0);

    // Push and correct resolve on the same edge keep count unchanged.
    push(8'h40, 1'b1); step();
    push(8'h41, 1'b1);
    res_valid = 1'b1;
    res_taken = 1'b1;
    step();
    check_out("push_pop", 1'b1, 8'h40, 1'b1, 1'b0, 3'd1);
    idle();
    res_valid = 1'b1;
    res_taken = 1'b1;
    step();
    check_out("push_pop_tail", 1'b1, 8'h41, 1'b1, 1'b0, 3'd0);
    idle();

    // Asynchronous reset between edges with a pulse pending.
    push(8'h50, 1'b1); step();
    push(8'h51, 1'b1); step();
    push(8'h52, 1'b1); step();
    push(8'h53, 1'b1);
    res_valid = 1'b1;
    res_taken = 1'b1;
    step();
    check_out("pre_async", 1'b1, 8'h50, 1'b1, 1'b0, 3'd3);
    idle();
    #2 rst = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
    check("async_rst.pred_ready", 32'(pred_ready), 32'd1);
    step();
    rst = 1'b0;
    step();

    // Integration with the bpcache write model.
    push(8'h05, 1'b0); step();
    idle();
    res_valid = 1'b1;
    res_taken = 1'b1;
    step();
    check_out("train1", 1'b1, 8'h05, 1'b1, 1'b1, 3'd0);
    idle();
    push(8'h05, 1'b0); step();
    idle();
    res_valid = 1'b1;
    res_taken = 1'b1;
    step();
    check_out("train2", 1'b1, 8'h05, 1'b1, 1'b1, 3'd0);
    idle();
    step();
    step();
    check("bpcache.branch@05", 32'(cache[8'h05]), 32'd1);
    check("bpcache.branch@10", 32'(cache[8'h10]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
